// File: rtl/blink_meter.sv
// -----------------------------------------------------------------------------
// blink_meter
//   Receives an external square-wave blink signal, synchronizes and debounces
//   it, then measures the time between accepted edges in clock cycles. Each
//   measured half-period is reported with a one-cycle valid pulse. Loss of
//   activity is detected after an idle timeout.
//
// Parameters
//   CLK_FREQ         clock frequency in Hz (only sets the TIMEOUT default)
//   DEBOUNCE_CYCLES  synchronized cycles a new level must hold (>= 1)
//   TIMEOUT_CYCLES   idle interval after which measurement is abandoned
//
// Ports
//   clk           in   system clock
//   rst           in   asynchronous active-high reset
//   blink_in      in   asynchronous blink signal from the pin
//   level         out  debounced input level
//   half_period   out  cycles between the last two accepted edges (held)
//   period_valid  out  one-cycle pulse when half_period is updated
//   active        out  high while a periodic signal is locked
//   edge_count    out  count of accepted edges, wraps at 16 bits
// -----------------------------------------------------------------------------
module blink_meter #(
   parameter int unsigned CLK_FREQ        = 25_000_000,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned TIMEOUT_CYCLES  = CLK_FREQ
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        blink_in,
   output logic        level,
   output logic [31:0] half_period,
   output logic        period_valid,
   output logic        active,
   output logic [15:0] edge_count
);

   // deb_cnt never exceeds DEBOUNCE_CYCLES-1, so clog2(DEBOUNCE_CYCLES) bits suffice.
   localparam int unsigned DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [31:0]      TIMEOUT  = 32'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_LOCKED
   } state_t;

   logic             r_sync_q1;
   logic             r_sync_q2;
   logic [DEB_W-1:0] r_deb_cnt;
   logic             r_level;
   logic [31:0]      r_int_cnt;
   state_t           r_state;
   logic             r_active;
   logic             r_period_valid;
   logic [31:0]      r_half_period;
   logic [15:0]      r_edge_count;

   logic             w_mismatch;
   logic             w_accept;
   logic             w_timeout;
   logic             w_report;
   state_t           w_state_next;

   // A new level is accepted on the cycle its hold count would reach
   // DEBOUNCE_CYCLES, giving a fixed 2 + DEBOUNCE_CYCLES pin-to-level delay.
   assign w_mismatch = (r_sync_q2 != r_level);
   assign w_accept   = w_mismatch && (r_deb_cnt == DEB_LAST);
   assign w_timeout  = (r_int_cnt == TIMEOUT);

   // Synchronizer and debounce
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync_q1 <= 1'b0;
         r_sync_q2 <= 1'b0;
         r_deb_cnt <= '0;
         r_level   <= 1'b0;
      end else begin
         r_sync_q1 <= blink_in;
         r_sync_q2 <= r_sync_q1;
         if (!w_mismatch || w_accept) begin
            r_deb_cnt <= '0;
         end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
         end
         if (w_accept) begin
            r_level <= ~r_level;
         end
      end
   end

   // Interval counter: restarts at 1 on an edge so that at the next edge it
   // holds the exact cycle distance; saturates at TIMEOUT to mark idleness.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_int_cnt <= '0;
      end else if (w_accept) begin
         r_int_cnt <= 32'd1;
      end else if (r_int_cnt < TIMEOUT) begin
         r_int_cnt <= r_int_cnt + 32'd1;
      end
   end

   // Next-state and report decode
   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_next = r_state;
      w_report     = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_next = S_ARMED;
            end
         end
         S_ARMED, S_LOCKED: begin
            if (w_accept) begin
               if (r_int_cnt < TIMEOUT) begin
                  w_report     = 1'b1;
                  w_state_next = S_LOCKED;
               end else begin
                  // Edge coinciding with timeout: measurement is void, but
                  // the edge still starts a fresh sequence.
                  w_state_next = S_ARMED;
               end
            end else if (w_timeout) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // State register and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_active       <= 1'b0;
         r_period_valid <= 1'b0;
         r_half_period  <= '0;
         r_edge_count   <= '0;
      end else begin
         r_state        <= w_state_next;
         r_active       <= (w_state_next == S_LOCKED);
         r_period_valid <= w_report;
         if (w_report) begin
            r_half_period <= r_int_cnt;
         end
         if (w_accept) begin
            r_edge_count <= r_edge_count + 16'd1;
         end
      end
   end

   assign level        = r_level;
   assign half_period  = r_half_period;
   assign period_valid = r_period_valid;
   assign active       = r_active;
   assign edge_count   = r_edge_count;

endmodule
